// File: rtl/motoro3_pkg.sv
// Shared motoro3 definitions: sequencer state encoding, step limits and the
// commutation step-group constants also used by the PWM generator.
package motoro3_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } m3_state_e;

   localparam logic [3:0]  STEP_LAST = 4'd11;
   localparam int unsigned MIN_LEN   = 4;

   // Step groups: every third step (four per cycle) and every sixth (two per cycle)
   localparam logic [3:0] STEP_GRP4 [4] = '{4'd0, 4'd3, 4'd6, 4'd9};
   localparam logic [3:0] STEP_GRP2 [2] = '{4'd0, 4'd6};

   function automatic logic f_isGrp4Start(input logic [3:0] step);
      return (step == STEP_GRP4[0]) || (step == STEP_GRP4[1]) ||
             (step == STEP_GRP4[2]) || (step == STEP_GRP4[3]);
   endfunction

   function automatic logic f_isGrp2Start(input logic [3:0] step);
      return (step == STEP_GRP2[0]) || (step == STEP_GRP2[1]);
   endfunction

endpackage

// File: rtl/motoro3_step_sequencer_if.sv
// Control/status bundle between the motoro3 register block (master) and the
// step sequencer (slave).
interface motoro3_step_sequencer_if #(
   parameter int unsigned CNT_W = 25,
   parameter int unsigned CYC_W = 16
);
   import motoro3_pkg::*;

   logic             m3r_runEn;
   logic             m3r_abort;
   logic [CNT_W-1:0] m3r_stepLen;
   logic [3:0]       sgStep;
   logic [CNT_W-1:0] m3cnt;
   logic             m3cntFirst2;
   logic             m3cntFirst1;
   logic             m3cntLast1;
   logic             m3cntLast2;
   logic             pwmActive1;
   logic             pwmLastStep1;
   logic             cycleDone;
   logic [CYC_W-1:0] cycleCnt;
   logic             busy;

   modport master (
      output m3r_runEn, m3r_abort, m3r_stepLen,
      input  sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast1, m3cntLast2,
             pwmActive1, pwmLastStep1, cycleDone, cycleCnt, busy
   );

   modport slave (
      input  m3r_runEn, m3r_abort, m3r_stepLen,
      output sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast1, m3cntLast2,
             pwmActive1, pwmLastStep1, cycleDone, cycleCnt, busy
   );

endinterface

// File: rtl/motoro3_step_sequencer.sv
// 12-step commutation sequencer: per-step down counter, step strobes and the
// run/last-step qualifiers feeding the motoro3 PWM generator.
module motoro3_step_sequencer #(
   parameter int unsigned CNT_W     = 25,
   parameter logic [3:0]  STEP_LAST = 4'd11,
   parameter int unsigned MIN_LEN   = 4,
   parameter int unsigned CYC_W     = 16
) (
   input logic                     clk,
   input logic                     nRst,
   motoro3_step_sequencer_if.slave bus
);
   import motoro3_pkg::*;

   m3_state_e        r_state;
   logic [3:0]       r_step;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_lenS;
   logic             r_stopPend;
   logic [CYC_W-1:0] r_cycCnt;

   m3_state_e        w_stateNxt;
   logic [3:0]       w_stepNxt;
   logic [CNT_W-1:0] w_cntNxt;
   logic [CNT_W-1:0] w_lenSNxt;
   logic             w_stopNxt;
   logic [CYC_W-1:0] w_cycNxt;
   logic [CNT_W-1:0] w_lenNew;
   logic             w_run;
   logic             w_cntZero;

   function automatic logic [CNT_W-1:0] f_effLen(input logic [CNT_W-1:0] len);
      return (len < CNT_W'(MIN_LEN)) ? CNT_W'(MIN_LEN) : len;
   endfunction

   function automatic logic [CYC_W-1:0] f_satInc(input logic [CYC_W-1:0] v);
      return (&v) ? v : v + CYC_W'(1);
   endfunction

   assign w_lenNew  = f_effLen(bus.m3r_stepLen);
   assign w_run     = (r_state == ST_RUN);
   assign w_cntZero = (r_cnt == '0);

   always_comb begin
      w_stateNxt = r_state;
      w_stepNxt  = r_step;
      w_cntNxt   = r_cnt;
      w_lenSNxt  = r_lenS;
      w_stopNxt  = r_stopPend;
      w_cycNxt   = r_cycCnt;

      unique case (r_state)
         ST_IDLE: begin
            if (bus.m3r_runEn) begin
               w_stateNxt = ST_RUN;
               w_stepNxt  = 4'd0;
               w_lenSNxt  = w_lenNew;
               w_cntNxt   = w_lenNew - CNT_W'(1);
               w_stopNxt  = 1'b0;
            end
         end
         ST_RUN: begin
            // A dropped runEn only arms the stop; the cycle always completes
            w_stopNxt = ~bus.m3r_runEn;
            if (!w_cntZero) begin
               w_cntNxt = r_cnt - CNT_W'(1);
            end else begin
               w_lenSNxt = w_lenNew;
               if (r_step != STEP_LAST) begin
                  w_stepNxt = r_step + 4'd1;
                  w_cntNxt  = w_lenNew - CNT_W'(1);
               end else begin
                  w_cycNxt  = f_satInc(r_cycCnt);
                  w_stepNxt = 4'd0;
                  if (r_stopPend) begin
                     w_stateNxt = ST_IDLE;
                     w_cntNxt   = '0;
                     w_stopNxt  = 1'b0;
                  end else begin
                     w_cntNxt = w_lenNew - CNT_W'(1);
                  end
               end
            end
         end
         default: begin
            w_stateNxt = ST_IDLE;
         end
      endcase

      // Abort overrides everything, including the end-of-cycle count
      if (bus.m3r_abort) begin
         w_stateNxt = ST_IDLE;
         w_stepNxt  = 4'd0;
         w_cntNxt   = '0;
         w_stopNxt  = 1'b0;
         w_cycNxt   = r_cycCnt;
      end
   end

   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state    <= ST_IDLE;
         r_step     <= 4'd0;
         r_cnt      <= '0;
         r_lenS     <= CNT_W'(MIN_LEN);
         r_stopPend <= 1'b0;
         r_cycCnt   <= '0;
      end else begin
         r_state    <= w_stateNxt;
         r_step     <= w_stepNxt;
         r_cnt      <= w_cntNxt;
         r_lenS     <= w_lenSNxt;
         r_stopPend <= w_stopNxt;
         r_cycCnt   <= w_cycNxt;
      end
   end

   // Strobes decode from registered state; lenS >= MIN_LEN keeps them disjoint
   assign bus.sgStep       = r_step;
   assign bus.m3cnt        = r_cnt;
   assign bus.m3cntFirst2  = w_run && (r_cnt == r_lenS - CNT_W'(1));
   assign bus.m3cntFirst1  = w_run && (r_cnt == r_lenS - CNT_W'(2));
   assign bus.m3cntLast1   = w_run && (r_cnt == CNT_W'(1));
   assign bus.m3cntLast2   = w_run && w_cntZero;
   assign bus.pwmActive1   = w_run;
   assign bus.pwmLastStep1 = w_run && r_stopPend && (r_step == STEP_LAST);
   assign bus.cycleDone    = w_run && w_cntZero && (r_step == STEP_LAST);
   assign bus.cycleCnt     = r_cycCnt;
   assign bus.busy         = w_run;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Bench for motoro3_step_sequencer: directed scenarios plus random control
// traffic, all outputs compared each clock against a behavioural model.
module tb_motoro3_step_sequencer;

   logic clk  = 1'b0;
   logic nRst = 1'b0;

   motoro3_step_sequencer_if #(.CNT_W(25), .CYC_W(16)) bus ();

   motoro3_step_sequencer #(
      .CNT_W(25), .STEP_LAST(4'd11), .MIN_LEN(4), .CYC_W(16)
   ) dut (
      .clk (clk),
      .nRst(nRst),
      .bus (bus)
   );

   always #50 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Model: m_left = clocks remaining in the step including the current one
   int m_run, m_step, m_left, m_len, m_stop, m_cyc;
   bit en, ab;
   int sl;
   int n;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_run = 0; m_step = 0; m_left = 0; m_len = 4; m_stop = 0; m_cyc = 0;
   endtask

   task automatic m_edge(input bit ren, input bit abt, input int slen);
      int eff;
      int stop_n;
      eff = (slen < 4) ? 4 : slen;
      if (abt) begin
         m_run = 0; m_step = 0; m_left = 0; m_stop = 0;
      end else if (m_run == 0) begin
         if (ren) begin
            m_run = 1; m_step = 0; m_len = eff; m_left = eff; m_stop = 0;
         end
      end else begin
         stop_n = ren ? 0 : 1;
         if (m_left > 1) m_left--;
         else if (m_step < 11) begin
            m_step++; m_len = eff; m_left = eff;
         end else begin
            if (m_cyc < 65535) m_cyc++;
            if (m_stop != 0) begin
               m_run = 0; m_step = 0; m_left = 0; stop_n = 0;
            end else begin
               m_step = 0; m_len = eff; m_left = eff;
            end
         end
         m_stop = stop_n;
      end
   endtask

   task automatic m_check();
      bit r;
      r = (m_run != 0);
      chk("sgStep", 64'(bus.sgStep), 64'(m_step));
      chk("m3cnt", 64'(bus.m3cnt), r ? 64'(m_left - 1) : 64'd0);
      chk("first2", 64'(bus.m3cntFirst2), 64'(r && m_left == m_len));
      chk("first1", 64'(bus.m3cntFirst1), 64'(r && m_left == m_len - 1));
      chk("last1", 64'(bus.m3cntLast1), 64'(r && m_left == 2));
      chk("last2", 64'(bus.m3cntLast2), 64'(r && m_left == 1));
      chk("pwmActive1", 64'(bus.pwmActive1), 64'(r));
      chk("pwmLastStep1", 64'(bus.pwmLastStep1), 64'(r && m_stop != 0 && m_step == 11));
      chk("cycleDone", 64'(bus.cycleDone), 64'(r && m_left == 1 && m_step == 11));
      chk("cycleCnt", 64'(bus.cycleCnt), 64'(m_cyc));
      chk("busy", 64'(bus.busy), 64'(r));
   endtask

   // One clock: drive on posedge, DUT and model update on negedge, sample 1ns later
   task automatic cyc();
      logic [31:0] slv;
      @(posedge clk);
      slv = sl;
      bus.m3r_runEn   = en;
      bus.m3r_abort   = ab;
      bus.m3r_stepLen = slv[24:0];
      @(negedge clk);
      m_edge(en, ab, sl);
      #1 m_check();
   endtask

   initial begin
      en = 0; ab = 0; sl = 10;
      bus.m3r_runEn = 0; bus.m3r_abort = 0; bus.m3r_stepLen = 25'd10;
      m_reset();

      // Reset state and first-step timing
      #20 m_check();
      @(negedge clk); #10 nRst = 1'b1;
      cyc();
      chk("idle_busy", 64'(bus.busy), 64'd0);
      en = 1;
      cyc();
      chk("start_cnt", 64'(bus.m3cnt), 64'd9);
      chk("start_first2", 64'(bus.m3cntFirst2), 64'd1);
      cyc();
      chk("cnt8_first1", 64'(bus.m3cntFirst1), 64'd1);
      for (int k = 0; k < 6; k++) cyc();
      cyc();
      chk("cnt1_last1", 64'(bus.m3cntLast1), 64'd1);
      cyc();
      chk("cnt0_last2", 64'(bus.m3cntLast2), 64'd1);
      cyc();
      chk("step1", 64'(bus.sgStep), 64'd1);
      chk("step1_cnt", 64'(bus.m3cnt), 64'd9);

      // Cycle wrap with no gap clock
      n = 0;
      while (n < 200 && !(bus.sgStep == 4'd11 && bus.m3cnt == '0)) begin cyc(); n++; end
      chk("reach_wrap", 64'(n < 200), 64'd1);
      chk("wrap_cycleDone", 64'(bus.cycleDone), 64'd1);
      cyc();
      chk("wrap_step", 64'(bus.sgStep), 64'd0);
      chk("wrap_cnt", 64'(bus.m3cnt), 64'd9);
      chk("wrap_cycCnt", 64'(bus.cycleCnt), 64'd1);

      // Graceful stop armed in step 4
      n = 0;
      while (n < 200 && bus.sgStep != 4'd4) begin cyc(); n++; end
      chk("reach_s4", 64'(n < 200), 64'd1);
      en = 0;
      n = 0;
      for (int k = 0; k < 300 && bus.busy; k++) begin cyc(); if (bus.pwmLastStep1) n++; end
      chk("stop_idle", 64'(bus.busy), 64'd0);
      chk("laststep_clocks", 64'(n), 64'd10);
      chk("stop_cycCnt", 64'(bus.cycleCnt), 64'd2);

      // Stop cancelled in step 8
      en = 1;
      cyc();
      n = 0;
      while (n < 200 && bus.sgStep != 4'd4) begin cyc(); n++; end
      en = 0;
      n = 0;
      while (n < 200 && bus.sgStep != 4'd8) begin cyc(); n++; end
      chk("reach_s8", 64'(n < 200), 64'd1);
      en = 1;
      n = 0;
      for (int k = 0; k < 200 && !(bus.sgStep == 4'd0 && bus.m3cnt == 25'd9); k++) begin
         cyc(); if (bus.pwmLastStep1) n++;
      end
      chk("cancel_laststep", 64'(n), 64'd0);
      chk("cancel_busy", 64'(bus.busy), 64'd1);

      // Length change mid-step affects only the next step
      n = 0;
      while (n < 200 && !(bus.sgStep == 4'd2 && bus.m3cnt == 25'd5)) begin cyc(); n++; end
      chk("reach_s2c5", 64'(n < 200), 64'd1);
      sl = 20;
      n = 0;
      while (n < 50 && bus.sgStep != 4'd3) begin cyc(); n++; end
      chk("s2_tail_clocks", 64'(n), 64'd6);
      chk("s3_cnt", 64'(bus.m3cnt), 64'd19);

      // Length clamp to MIN_LEN
      sl = 2;
      n = 0;
      while (n < 100 && bus.sgStep != 4'd4) begin cyc(); n++; end
      for (int k = 0; k < 4; k++) begin
         if (k > 0) cyc();
         chk("clamp_cnt", 64'(bus.m3cnt), 64'(3 - k));
         chk("clamp_f2", 64'(bus.m3cntFirst2), 64'(k == 0));
         chk("clamp_f1", 64'(bus.m3cntFirst1), 64'(k == 1));
         chk("clamp_l1", 64'(bus.m3cntLast1), 64'(k == 2));
         chk("clamp_l2", 64'(bus.m3cntLast2), 64'(k == 3));
      end

      // Abort in step 7 with m3cnt = 3
      n = 0;
      while (n < 100 && !(bus.sgStep == 4'd7 && bus.m3cnt == 25'd3)) begin cyc(); n++; end
      chk("reach_s7c3", 64'(n < 100), 64'd1);
      ab = 1;
      cyc();
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_cycCnt", 64'(bus.cycleCnt), 64'(m_cyc));
      ab = 0; sl = 10;

      // Async reset mid-step 9
      n = 0;
      while (n < 200 && !(bus.sgStep == 4'd9 && bus.m3cnt == 25'd6)) begin cyc(); n++; end
      chk("reach_s9", 64'(n < 200), 64'd1);
      #20 nRst = 1'b0;
      #1 m_reset();
      m_check();
      @(negedge clk); #10 nRst = 1'b1;

      // Widest legal length
      sl = 32'h01FF_FFFF;
      cyc();
      chk("wide_cnt", 64'(bus.m3cnt), 64'h1FF_FFFE);
      cyc(); cyc();
      ab = 1; cyc(); ab = 0;

      // Random control traffic
      sl = 6;
      for (int i = 0; i < 4000; i++) begin
         en = ($urandom_range(0, 99) < 85);
         ab = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) sl = $urandom_range(0, 12);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #20_000_000;
      $display("FAIL timeout: simulation did not end, got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/motoro3_step_sequencer.md
Name: motoro3_step_sequencer

Overview:
- Upstream timing source for motoro3 PWM generation.
- Runs the 12-step electrical commutation cycle (sgStep 0..11). Each step lasts a programmable number of 10 MHz clocks.
- Per step it produces a down-counting step counter m3cnt and first/last-cycle strobes. It also produces the pwmActive1 and pwmLastStep1 qualifiers that the PWM generator consumes directly.
- Handles start, graceful stop at a cycle boundary, and immediate abort.

Parameters:
- CNT_W, 25, width of m3cnt and m3r_stepLen.
- STEP_LAST, 11, index of the final commutation step.
- MIN_LEN, 4, minimum effective step length in clocks.
- CYC_W, 16, width of the completed-cycle counter.

Ports:
- clk  in  1  10 MHz system clock; all state updates on negedge clk.
- nRst  in  1  reset, asynchronous, active-low.
- m3r_runEn  in  1  level; 1 = run requested, 0 = stop at end of current electrical cycle.
- m3r_abort  in  1  level; 1 = stop immediately.
- m3r_stepLen  in  CNT_W  clocks per step; sampled only at step boundaries.
- sgStep  out  4  current commutation step, 0..11.
- m3cnt  out  CNT_W  remaining clocks in the step; counts lenS-1 down to 0.
- m3cntFirst2  out  1  first clock of a step (m3cnt == lenS-1).
- m3cntFirst1  out  1  second clock of a step (m3cnt == lenS-2).
- m3cntLast1  out  1  second-to-last clock of a step (m3cnt == 1).
- m3cntLast2  out  1  last clock of a step (m3cnt == 0).
- pwmActive1  out  1  1 while in RUN.
- pwmLastStep1  out  1  1 during the final step before termination.
- cycleDone  out  1  one-clock pulse on the Last2 clock of step 11.
- cycleCnt  out  CYC_W  completed electrical cycles; saturating.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (nRst low, async):
  - state = IDLE, sgStep = 0, m3cnt = 0, lenS = MIN_LEN.
  - stopPend = 0, cycleCnt = 0.
  - All strobes, pwmActive1, pwmLastStep1, cycleDone and busy are 0.
- Effective length: lenS = max(m3r_stepLen, MIN_LEN). It is registered from m3r_stepLen on IDLE->RUN and on every Last2 clock in RUN. A length change mid-step affects only the next step.
- States:
  - IDLE -> RUN when m3r_runEn = 1 and m3r_abort = 0. On that edge: sgStep = 0, m3cnt = lenS_new-1, stopPend = 0.
  - RUN, m3cnt != 0: m3cnt decrements by 1.
  - RUN, m3cnt == 0 and sgStep < 11: sgStep increments; m3cnt = lenS_new-1.
  - RUN, m3cnt == 0 and sgStep == 11 and stopPend = 0: sgStep = 0; m3cnt reloads; cycleCnt increments (saturates at all-ones).
  - RUN, m3cnt == 0 and sgStep == 11 and stopPend = 1: go to IDLE with sgStep = 0, m3cnt = 0. cycleCnt still increments.
  - Any state with m3r_abort = 1: next edge goes to IDLE with sgStep = 0, m3cnt = 0, stopPend = 0. Abort has priority over all other events.
- stopPend:
  - Set on any RUN clock with m3r_runEn = 0.
  - Cleared when m3r_runEn = 1 before termination (stop cancelled).
  - Only a complete electrical cycle ever ends normally.
- pwmLastStep1 = RUN & stopPend & (sgStep == 11).
- Strobes, cycleDone and pwmActive1 are decoded from registered state/m3cnt, qualified by RUN. They are all 0 in IDLE.
- Strobes never overlap: MIN_LEN = 4 guarantees First2, First1, Last1 and Last2 fall on distinct clocks.
- Throughput: each step is exactly lenS clocks, with no dead clock between steps or between cycles.
- m3r_stepLen wider than needed is not truncated; any value up to 2^CNT_W-1 is legal.

Decomposition:
- Shared package motoro3_pkg holds:
  - state encoding (IDLE = 0, RUN = 1);
  - STEP_LAST = 4'd11;
  - MIN_LEN = 4;
  - the step-group constants 0/3/6/9 and 0/6, reused by the PWM generator's accumulators.
- No sub-module. Strobe decode and FSM stay in a single module, about 150-200 lines.

Test Plan:
1. Check reset and step timing:
   - Stimulus: nRst low, then high with runEn = 0.
   - Response: all outputs 0, busy = 0.
   - Then stepLen = 10, runEn = 1. Response: after one edge, pwmActive1 = 1, sgStep = 0, m3cnt = 9, First2 = 1. Next clock m3cnt = 8 with First1 = 1. Then m3cnt = 1 with Last1 = 1, then m3cnt = 0 with Last2 = 1. Then sgStep = 1 with m3cnt = 9.
2. Check cycle wrap:
   - Stimulus: stepLen = 10, run for 120 clocks.
   - Response: cycleDone = 1 on sgStep = 11 with m3cnt = 0. Next clock sgStep = 0, m3cnt = 9, cycleCnt = 1. No gap clock.
3. Check graceful stop and stop cancel:
   - Stimulus: runEn dropped during step 4.
   - Response: sequence continues to step 11. pwmLastStep1 = 1 for exactly 10 clocks of step 11. Then IDLE: pwmActive1 = 0, sgStep = 0, m3cnt = 0, cycleCnt incremented.
   - Repeat, re-raising runEn in step 8. Response: no stop, pwmLastStep1 stays 0.
4. Check length update timing:
   - Stimulus: stepLen changed 10 -> 20 when m3cnt = 5 in step 2.
   - Response: step 2 still ends at m3cnt = 0 after 10 clocks total. Step 3 starts at m3cnt = 19.
5. Check length clamp:
   - Stimulus: stepLen = 2.
   - Response: each step lasts 4 clocks (m3cnt 3,2,1,0). First2, First1, Last1 and Last2 each fire once per step, on distinct clocks.
6. Check abort and mid-run reset:
   - Stimulus: abort = 1 while in step 7 with m3cnt = 3.
   - Response: next edge IDLE, all strobes 0, cycleCnt unchanged.
   - Stimulus: nRst pulsed low mid-step 9.
   - Response: outputs 0 immediately, without waiting for a clock edge.
